data_mem: RTL and testbench

- Word-organised data memory with RV32I load/store sizing. Sits directly downstream of the ALU: the ALU result is the effective address, and the rs2 value is the store data.
- Provides combinational, single-cycle-compatible load data and clocked stores.
- Detects misaligned, illegal and out-of-range accesses, suppresses them, and records the first one in a sticky fault register for debug and a future trap unit.

---
 rtl/mem_pkg.sv | 14 +
 rtl/data_mem_load_align.sv | 20 ++
 rtl/data_mem.sv | 86 ++++++++
 tb/tb_data_mem.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: RV32I load/store size encodings and fault cause codes for the data memory.
package mem_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    typedef enum logic [1:0] {
        NONE     = 2'b00,
        MISALIGN = 2'b01,
        RANGE    = 2'b10,
        ILLEGAL  = 2'b11
    } fault_cause_e;
endpackage

// File: rtl/data_mem_load_align.sv
// load_align: picks the addressed byte/half out of a word and sign- or zero-extends it.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b = word[{addr_lo, 3'b000} +: 8];
        h = addr_lo[1] ? word[31:16] : word[15:0];
        result = funct3 == F3_B  ? {{24{b[7]}}, b}  :
                 funct3 == F3_BU ? {24'h0, b}        :
                 funct3 == F3_H  ? {{16{h[15]}}, h} :
                 funct3 == F3_HU ? {16'h0, h}        : word;
    end
endmodule

// File: rtl/data_mem.sv
// data_mem: word-organised data memory with combinational loads, clocked byte-lane stores
// and a sticky record of the first faulting access.
module data_mem
    import mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata,
    output logic        access_err,
    output logic        fault_sticky,
    output logic [1:0]  fault_cause,
    output logic [31:0] fault_addr
);
    localparam int IW = $clog2(DEPTH_WORDS);

    logic [31:0]  mem [DEPTH_WORDS];
    logic [31:0]  off, aligned, lane_data;
    logic [IW-1:0] idx;
    logic [3:0]   be;
    logic         out_of_range, illegal, misalign, we;
    fault_cause_e cur_cause;
    logic         fault_sticky_d, fault_sticky_q;
    fault_cause_e fault_cause_d, fault_cause_q;
    logic [31:0]  fault_addr_d, fault_addr_q;

    // off[1:0] equals addr[1:0] because BASE_ADDR is word aligned
    always_comb begin
        off = addr - BASE_ADDR;
        idx = off[IW+1:2];
        out_of_range = off[31:IW+2] != '0;
        illegal = funct3 inside {3'b011, 3'b110, 3'b111}
                  || (mem_wr && funct3 inside {F3_BU, F3_HU})
                  || (mem_rd && mem_wr);
        misalign = (funct3 inside {F3_H, F3_HU} && off[0])
                   || (funct3 == F3_W && off[1:0] != 2'b00);
        cur_cause = illegal ? ILLEGAL : out_of_range ? RANGE : misalign ? MISALIGN : NONE;
        access_err = (mem_rd || mem_wr) && cur_cause != NONE;
        we = mem_wr && !access_err;
        be = funct3 == F3_B ? 4'b0001 << off[1:0] :
             funct3 == F3_H ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        lane_data = funct3 == F3_B ? {4{wdata[7:0]}} :
                    funct3 == F3_H ? {2{wdata[15:0]}} : wdata;
        rdata = (mem_rd && !access_err) ? aligned : 32'h0;
        fault_sticky_d = fault_sticky_q || access_err;
        fault_cause_d = (access_err && !fault_sticky_q) ? cur_cause : fault_cause_q;
        fault_addr_d = (access_err && !fault_sticky_q) ? addr : fault_addr_q;
    end

    load_align u_load_align (
        .word    (mem[idx]),
        .addr_lo (off[1:0]),
        .funct3  (funct3),
        .result  (aligned)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fault_sticky_q <= 1'b0;
            fault_cause_q  <= NONE;
            fault_addr_q   <= 32'h0;
        end else begin
            fault_sticky_q <= fault_sticky_d;
            fault_cause_q  <= fault_cause_d;
            fault_addr_q   <= fault_addr_d;
        end
    end

    // array is deliberately not reset so contents survive rst_n
    always_ff @(posedge clk) begin
        if (rst_n && we)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= lane_data[8*i +: 8];
    end

    assign fault_sticky = fault_sticky_q;
    assign fault_cause  = fault_cause_q;
    assign fault_addr   = fault_addr_q;
endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: randomized + directed scoreboard bench for data_mem against a byte-array model.
module tb_data_mem;
    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam int          NBYTES = 4096;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr, wdata, rdata, fault_addr;
    logic        mem_rd, mem_wr, access_err, fault_sticky;
    logic [2:0]  funct3;
    logic [1:0]  fault_cause;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        sticky;
        logic [1:0]  cause;
        logic [31:0] faddr;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad = 0;
    logic [7:0]  mb [NBYTES];
    logic        m_sticky;
    logic [1:0]  m_cause;
    logic [31:0] m_faddr;

    always #5 clk = ~clk;

    data_mem #(.DEPTH_WORDS(1024), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .funct3(funct3),
        .rdata(rdata), .access_err(access_err), .fault_sticky(fault_sticky),
        .fault_cause(fault_cause), .fault_addr(fault_addr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (mem_rd || mem_wr)) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_underflow: got empty queue expected an entry");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("rdata", rdata, e.rdata);
                chk("access_err", 32'(access_err), 32'(e.err));
                chk("fault_sticky", 32'(fault_sticky), 32'(e.sticky));
                chk("fault_cause", 32'(fault_cause), 32'(e.cause));
                chk("fault_addr", fault_addr, e.faddr);
            end
        end
    end

    // Reference: sizes as byte counts, memory as a flat byte array, faults from the rule list
    task automatic op(input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] o;
        logic [63:0] val;
        logic        oor, ill, mis, err;
        logic [1:0]  cause;
        int          n;
        exp_t        e;
        @(posedge clk);
        #1;
        rst_n = 1'b1; mem_rd = rd; mem_wr = wr; funct3 = f3; addr = a; wdata = wd;
        n = 1 << f3[1:0];
        o = a - BASE;
        oor = o >= 32'(NBYTES);
        ill = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) || (wr && f3[2]) || (rd && wr);
        mis = !ill && (a % n) != 0;
        cause = ill ? 2'd3 : oor ? 2'd2 : mis ? 2'd1 : 2'd0;
        err = (rd || wr) && cause != 2'd0;
        val = 64'h0;
        if (rd && !err) begin
            for (int i = 0; i < n; i++) val = val | (64'(mb[o[11:0] + 12'(i)]) << (8 * i));
            if (!f3[2] && val[8*n-1]) val = val | (~64'h0 << (8 * n));
        end
        e.rdata = val[31:0]; e.err = err;
        e.sticky = m_sticky; e.cause = m_cause; e.faddr = m_faddr;
        if (rd || wr) sb_q.push_back(e);
        if (wr && !err)
            for (int i = 0; i < n; i++) mb[o[11:0] + 12'(i)] = wd[8*i +: 8];
        if (err && !m_sticky) begin
            m_sticky = 1'b1; m_cause = cause; m_faddr = a;
        end
    endtask

    task automatic reset_with_store(input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk);
        #1;
        rst_n = 1'b0; mem_rd = 1'b0; mem_wr = 1'b1; funct3 = 3'b010; addr = a; wdata = wd;
        m_sticky = 1'b0; m_cause = 2'd0; m_faddr = 32'h0;
    endtask

    initial begin
        rst_n = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
        m_sticky = 1'b0; m_cause = 2'd0; m_faddr = 32'h0;
        repeat (3) @(posedge clk);
        for (int w = 0; w < 1024; w++) op(1'b0, 1'b1, 3'b010, BASE + 32'(4 * w), $urandom);
        op(0, 1, 3'b010, BASE + 32'h10, 32'hDEADBEEF);
        op(1, 0, 3'b010, BASE + 32'h10, 32'h0);
        op(1, 0, 3'b000, BASE + 32'h10, 32'h0);
        op(1, 0, 3'b100, BASE + 32'h13, 32'h0);
        op(1, 0, 3'b001, BASE + 32'h12, 32'h0);
        op(1, 0, 3'b101, BASE + 32'h10, 32'h0);
        op(0, 1, 3'b010, BASE + 32'h20, 32'h0);
        op(0, 1, 3'b000, BASE + 32'h21, 32'hFFFF_FFAB);
        op(0, 1, 3'b001, BASE + 32'h22, 32'hFFFF_1234);
        op(1, 0, 3'b010, BASE + 32'h20, 32'h0);
        op(1, 0, 3'b010, BASE + 32'h24, 32'h0);
        op(0, 1, 3'b001, BASE + 32'h31, 32'h1111_1111);
        op(0, 1, 3'b010, BASE + 32'h22, 32'h2222_2222);
        op(1, 0, 3'b010, BASE + 32'h20, 32'h0);
        op(1, 0, 3'b010, BASE + 32'h1000, 32'h0);
        op(1, 0, 3'b010, 32'h0, 32'h0);
        op(1, 1, 3'b010, BASE + 32'h40, 32'h3333_3333);
        op(0, 1, 3'b100, BASE + 32'h40, 32'h4444_4444);
        op(1, 0, 3'b010, BASE + 32'h40, 32'h0);
        reset_with_store(BASE + 32'h40, 32'h5555_5555);
        op(1, 0, 3'b010, BASE + 32'h40, 32'h0);
        op(1, 0, 3'b010, 32'h0, 32'h0);
        op(1, 0, 3'b000, BASE + 32'h40, 32'h0);
        reset_with_store(BASE + 32'h44, 32'h6666_6666);
        op(1, 1, 3'b010, BASE + 32'h40, 32'h0);
        op(1, 0, 3'b010, BASE + 32'h44, 32'h0);
        reset_with_store(BASE + 32'h48, 32'h7777_7777);
        op(0, 1, 3'b010, BASE + 32'h40, 32'h11);
        op(1, 1, 3'b010, BASE + 32'h40, 32'h55);
        op(1, 0, 3'b010, BASE + 32'h40, 32'h0);
        op(0, 1, 3'b010, BASE + 32'h40, 32'h55);
        op(1, 0, 3'b010, BASE + 32'h40, 32'h0);
        for (int k = 0; k < 600; k++) begin
            logic [2:0]  f3;
            logic [31:0] o, a;
            logic        rd, wr;
            int          sel;
            if (k % 60 == 59) reset_with_store(BASE + 32'($urandom_range(0, 1023) * 4), $urandom);
            sel = $urandom_range(0, 19);
            f3 = sel < 4 ? 3'b000 : sel < 8 ? 3'b001 : sel < 12 ? 3'b010 :
                 sel < 15 ? 3'b100 : sel < 18 ? 3'b101 : 3'($urandom_range(3, 7));
            o = 32'($urandom_range(0, NBYTES + 63));
            if ($urandom_range(0, 9) != 0) o = o & ~32'((1 << f3[1:0]) - 1);
            a = $urandom_range(0, 24) == 0 ? $urandom : BASE + o;
            sel = $urandom_range(0, 19);
            rd = sel < 10 || sel == 19;
            wr = sel >= 10;
            op(rd, wr, f3, a, $urandom);
        end
        @(posedge clk);
        #1;
        mem_rd = 1'b0; mem_wr = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
